// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared FIFO geometry, output buffer depth and pointer helper
package fifo_rd_stream_pkg;
    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_PTR   = 4;
    localparam int BUF_DEPTH  = 3;
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/stream_buf3.sv
// stream_buf3: 3-entry circular byte buffer with push/pop, occupancy and head
module stream_buf3
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [2:0]       occ_sum;
    assign occ_sum = {1'b0, occ} + {2'b0, push} - {2'b0, pop};
    assign head    = (occ != 2'd0) ? mem[rd_ptr] : '0;
    // storage is never cleared; an empty buffer presents zero on head
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
    // pointer and occupancy tracking; the issue rule upstream keeps occ within 0..3
    always_ff @(posedge clk)
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 2'd0;
        end else begin
            assert (occ_sum <= 3'd3);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            occ <= occ_sum[1:0];
        end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the FIFO read port into a buffered valid/ready byte stream
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_rdempty,
    input  logic [WIDTH-1:0] fifo_dataout,
    output logic             fifo_rden,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [1:0]       buf_occ
);
    logic       inflight;
    logic       pop;
    logic [1:0] occ;
    assign fifo_rden = !reset && !fifo_rdempty && (({1'b0, occ} + {2'b0, inflight}) < 3'(BUF_DEPTH));
    assign out_valid = occ != 2'd0;
    assign pop       = out_valid && out_ready;
    assign buf_occ   = occ;
    // a read issued this cycle returns data next cycle
    always_ff @(posedge clk)
        inflight <= reset ? 1'b0 : fifo_rden;
    // completed-transfer counter, wraps freely
    always_ff @(posedge clk)
        if (reset) xfer_cnt <= '0;
        else if (pop) xfer_cnt <= xfer_cnt + CNT_W'(1);
    stream_buf3 #(.WIDTH(WIDTH)) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .din   (fifo_dataout),
        .pop   (pop),
        .occ   (occ),
        .head  (out_data)
    );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of fifo_rd_stream against a queue FIFO model
module tb_fifo_rd_stream;
    logic       clk;
    logic       reset;
    logic       fifo_rdempty;
    logic [7:0] fifo_dataout;
    logic       fifo_rden;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [3:0] xfer_cnt;
    logic [1:0] buf_occ;

    fifo_rd_stream #(.WIDTH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_rdempty (fifo_rdempty),
        .fifo_dataout (fifo_dataout),
        .fifo_rden    (fifo_rden),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .xfer_cnt     (xfer_cnt),
        .buf_occ      (buf_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] q[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] held;
    logic       stalled;
    logic       rd;
    int total = 0;
    int bad = 0;
    int ncyc = 0;
    int nrden, nvalid, rden_cnt, first_rden, first_valid, first_fire, last_fire;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic clr();
        got.delete();
        exp_q.delete();
        nrden = 0; nvalid = 0; rden_cnt = 0;
        first_rden = -1; first_valid = -1; first_fire = -1; last_fire = -1;
        stalled = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        exp_q.push_back(b);
        fifo_rdempty <= 1'b0;
    endtask

    // one clock: sample outputs mid-cycle, then advance the FIFO model at the edge
    task automatic cyc(input logic r);
        out_ready = r;
        #1;
        ncyc++;
        if (stalled) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, held);
        end
        if (fifo_rden) begin nrden++; if (first_rden < 0) first_rden = ncyc; end
        if (out_valid) begin nvalid++; if (first_valid < 0) first_valid = ncyc; end
        if (out_valid && out_ready && !reset) begin
            got.push_back(out_data);
            if (first_fire < 0) first_fire = ncyc;
            last_fire = ncyc;
        end
        stalled = out_valid && !out_ready && !reset;
        held = out_data;
        rd = fifo_rden;
        @(posedge clk);
        if (rd) rden_cnt++;
        if (rd && q.size() > 0) fifo_dataout <= q.pop_front();
        fifo_rdempty <= (q.size() == 0);
        #1;
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(tag, got[i], exp_q[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0);
        cyc(0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        fifo_rdempty <= 1'b1;
        fifo_dataout <= 8'h00;
        clr();
        @(posedge clk);
        #1;
        cyc(0);
        push(8'h77);
        #1;
        chk("rst_rden", fifo_rden, 0);
        q.delete();
        fifo_rdempty <= 1'b1;
        cyc(0);
        chk("rst_valid", out_valid, 0);
        chk("rst_occ", buf_occ, 0);
        chk("rst_cnt", xfer_cnt, 0);
        chk("rst_data", out_data, 0);
        reset = 1'b0;

        clr();
        push(8'h11); push(8'h22); push(8'h33);
        for (int i = 0; i < 8; i++) cyc(1);
        chk("t1_rden", rden_cnt, 3);
        chk_seq("t1_seq");
        chk("t1_lat", first_valid - first_rden, 2);
        chk("t1_gap", last_fire - first_fire, 2);
        chk("t1_cnt", xfer_cnt, 3);

        clr();
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        for (int i = 0; i < 3; i++) cyc(0);
        chk("t5_occ", buf_occ, 2);
        chk("t5_rden_hold", fifo_rden, 0);
        chk("t5_rden", rden_cnt, 3);
        reset = 1'b1;
        cyc(0);
        reset = 1'b0;
        chk("t5_occ0", buf_occ, 0);
        chk("t5_valid0", out_valid, 0);
        chk("t5_cnt0", xfer_cnt, 0);
        exp_q.delete();
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h54);
        for (int i = 0; i < 8; i++) cyc(1);
        chk_seq("t5_seq");
        chk("t5_cnt", xfer_cnt, 2);

        do_reset();
        clr();
        for (int i = 0; i < 10; i++) push(8'(i));
        for (int i = 0; i < 8; i++) cyc(0);
        chk("t2_occ", buf_occ, 3);
        chk("t2_rden", rden_cnt, 3);
        chk("t2_left", q.size(), 7);
        chk("t2_valid", out_valid, 1);
        for (int i = 0; i < 14; i++) cyc(1);
        chk_seq("t2_seq");
        chk("t2_gap", last_fire - first_fire, 9);
        chk("t2_cnt", xfer_cnt, 10);

        do_reset();
        clr();
        for (int i = 0; i < 20; i++) cyc(1);
        chk("t3_rden", nrden, 0);
        chk("t3_valid", nvalid, 0);

        do_reset();
        clr();
        for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
        for (int i = 0; i < 50; i++) cyc(i % 2 == 0);
        chk_seq("t4_seq");
        chk("t4_cnt", xfer_cnt, 0);
        chk("t4_occ", buf_occ, 0);

        do_reset();
        clr();
        for (int i = 0; i < 17; i++) push(8'hC0 + 8'(i));
        for (int i = 0; i < 25; i++) cyc(1);
        chk_seq("t6_seq");
        chk("t6_cnt", xfer_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Downstream consumer of the 16x8 two-clock FIFO's read port. Runs in the FIFO read-clock domain.
- Drives the FIFO's rden, absorbs its 1-cycle registered dataout latency, and presents a valid/ready byte stream to the next stage.
- Holds a 3-entry output buffer, so throughput is 1 byte/cycle with no combinational path from out_ready to fifo_rden.
- Keeps a transfer counter for debug.

Parameters:
- WIDTH, 8, data width; must equal the FIFO WIDTH.
- CNT_W, 16, width of the xfer_cnt transfer counter.

Ports:
- clk  input  1  read-side clock; same net as the FIFO rdclk.
- reset  input  1  synchronous, active-high reset.
- fifo_rdempty  input  1  FIFO rdempty (combinational in FIFO).
- fifo_dataout  input  WIDTH  FIFO dataout; valid the cycle after an accepted rden.
- fifo_rden  output  1  read request to FIFO.
- out_valid  output  1  out_data holds a valid byte.
- out_data  output  WIDTH  head-of-buffer byte.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- xfer_cnt  output  CNT_W  count of completed output transfers, wraps modulo 2**CNT_W.
- buf_occ  output  2  current buffer occupancy, 0..3.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - fifo_rden=0 (held low during reset).
  - out_valid=0, buf_occ=0, xfer_cnt=0, inflight=0, rd_ptr=wr_ptr=0.
  - out_data=0 (buffer storage not cleared).
- Internal state:
  - inflight (1b) = registered fifo_rden.
  - 3-entry circular buffer with 2-bit wr_ptr and rd_ptr, each wrapping 2->0.
  - occ (2b).
- Issue rule (combinational from registers plus fifo_rdempty only):
  - fifo_rden = !reset && !fifo_rdempty && (occ + inflight < 3).
  - The sum is computed in 3 bits. out_ready does not enter this rule.
- Capture: if inflight==1, fifo_dataout is written at wr_ptr on this edge and wr_ptr advances.
- Pop: if out_valid && out_ready, rd_ptr advances and xfer_cnt increments.
- Occupancy update:
  - occ_next = occ + inflight - pop.
  - Simultaneous capture and pop leaves occ unchanged.
  - Overflow is impossible by the issue rule. Add an assertion that occ never exceeds 3.
- Outputs:
  - out_valid = (occ != 0).
  - out_data = buf[rd_ptr], combinational read of registered storage.
  - out_data must hold stable while out_valid && !out_ready.
  - buf_occ = occ.
- Latency:
  - Byte present in an empty FIFO, with occ=0 and inflight=0: fifo_rden asserts in cycle N.
  - out_valid rises at the clk edge ending cycle N+1, i.e. 2 edges from rden.
- Throughput: with out_ready held high and the FIFO non-empty, fifo_rden stays high every cycle and out_valid stays high continuously after fill.
- Backpressure:
  - With out_ready low, at most 3 bytes are buffered.
  - fifo_rden deasserts once occ + inflight == 3. The FIFO keeps the remaining bytes.
- Empty: fifo_rdempty=1 forces fifo_rden=0. Buffered bytes continue to drain.
- Ordering: output order equals FIFO read order, including across the buffer pointer wrap (2->0).
- Reset mid-operation:
  - The buffer and inflight are discarded.
  - A byte whose read was accepted in the cycle before reset is lost, because the FIFO pointer has already advanced. This is documented, intended behaviour.
- xfer_cnt wraps 2**CNT_W-1 -> 0 without saturating.

Decomposition:
- Shared package:
  - FIFO_WIDTH=8, FIFO_DEPTH=16, FIFO_PTR=4.
  - BUF_DEPTH=3 constant.
  - A ptr_inc function wrapping modulo BUF_DEPTH.
- Sub-module: stream_buf3, the 3-entry circular buffer with push/pop/occ/head. The top holds the issue logic, the inflight register and the counter.

Test Plan:
- Load bytes 0x11,0x22,0x33 into the FIFO, out_ready=1:
  - fifo_rden high for 3 cycles.
  - out_data sequence is 0x11,0x22,0x33 on consecutive cycles, first valid 2 edges after the first rden.
  - xfer_cnt=3.
- Load 10 bytes 0x00..0x09, out_ready=0:
  - buf_occ reaches 3; exactly 3 rden pulses; FIFO still holds 7.
  - Then out_ready=1: all 10 bytes emerge in order with no gap after the first.
- FIFO empty with out_ready=1 for 20 cycles: fifo_rden=0 and out_valid=0 throughout.
- Toggle out_ready 1,0,1,0 while streaming 16 bytes 0xA0..0xAF:
  - No loss, no duplication, correct order.
  - Buffer pointer wrap exercised.
  - out_data stable in every stalled cycle.
- Assert reset for 1 cycle while buf_occ=2 and inflight=1:
  - Next cycle buf_occ=0, out_valid=0, xfer_cnt=0.
  - The following FIFO bytes are delivered correctly after reset.
- With CNT_W=4, stream 17 bytes: xfer_cnt reads 1 after the wrap.
